// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with private HI/LO registers.
// The full result is computed at the start edge and parked in pending
// registers. A down-counter then models the latency, and the parked result
// is committed to HI/LO when the counter expires.
module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       mduOp,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  // Single-bit state so busy is a flop output with no decode in front of it.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  op_e                op;
  logic               is_mul, is_div, is_long, accept, done;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic               a_neg, b_neg, div_signed, div_zero;
  logic [WIDTH-1:0]   div_a, div_b, q_mag, r_mag, quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_wr;

  assign op      = op_e'(mduOp);
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_long = is_mul || is_div;
  assign accept  = start && (state_q == S_IDLE);
  assign done    = (state_q == S_BUSY) && (cnt_q == CW'(1));

  // Shared multiplier and divider. The signed variants only differ in how
  // the operands are extended or folded to magnitudes beforehand.
  always_comb begin
    mul_a      = {{WIDTH{(op == OP_MULT) & srcA[WIDTH-1]}}, srcA};
    mul_b      = {{WIDTH{(op == OP_MULT) & srcB[WIDTH-1]}}, srcB};
    prod       = mul_a * mul_b;

    div_signed = (op == OP_DIV);
    a_neg      = div_signed & srcA[WIDTH-1];
    b_neg      = div_signed & srcB[WIDTH-1];
    div_a      = a_neg ? -srcA : srcA;
    div_b      = b_neg ? -srcB : srcB;
    div_zero   = (srcB == '0);
    q_mag      = div_zero ? '0 : div_a / div_b;
    r_mag      = div_zero ? '0 : div_a % div_b;
    // Truncating division: quotient sign from operand signs, remainder
    // follows the dividend. Most-negative / -1 wraps back to most-negative.
    quo        = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;

    res_hi     = is_mul ? prod[2*WIDTH-1:WIDTH] : rem;
    res_lo     = is_mul ? prod[WIDTH-1:0]       : quo;
    // Divide by zero still runs the full latency but commits nothing.
    res_wr     = is_mul || !div_zero;
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Next-state logic: enter BUSY on an accepted mult/div, leave on expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_long) state_d = S_BUSY;
      S_BUSY:  if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: capture, count down, commit, and mthi/mtlo writes.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (state_q == S_BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (done && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (accept) begin
      case (op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          cnt_d     = is_mul ? MULT_N : DIV_N;
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_wr_d = res_wr;
        end
        OP_MTHI: hi_d = srcA;
        OP_MTLO: lo_d = srcA;
        default: ;
      endcase
    end
  end

  // Outputs are driven straight from flops.
  always_comb begin
    busy = (state_q == S_BUSY);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized scoreboard bench for mdu. The driver pushes expected
// HI/LO, latency and busy width per command. The monitor pops entries when a
// mult/div completes (busy falls) or when an immediate op or reset is due.
// Two DUTs are used: default latencies (5/10) and short ones (1/3).
module tb_mdu;
  localparam int W = 32;

  typedef enum logic [1:0] {K_RST, K_IMM, K_LONG} kind_e;
  typedef struct {
    kind_e        kind;
    int           dut;
    int           due;
    int           width;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] srcA = '0, srcB = '0;
  logic [2:0]   mduOp = '0;
  logic [1:0]   start = '0;
  logic [1:0]   busy;
  logic [W-1:0] hi0, lo0, hi1, lo1;

  always #5 clk = ~clk;

  mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut0 (
    .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB), .mduOp(mduOp),
    .start(start[0]), .busy(busy[0]), .hi(hi0), .lo(lo0));

  mdu #(.WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB), .mduOp(mduOp),
    .start(start[1]), .busy(busy[1]), .hi(hi1), .lo(lo1));

  exp_t         sb[$];
  int           checks = 0, failures = 0, cyc = 0;
  int           mc[2] = '{5, 1};
  int           dc[2] = '{10, 3};
  logic [W-1:0] m_hi[2] = '{0, 0};
  logic [W-1:0] m_lo[2] = '{0, 0};
  int           m_done[2] = '{0, 0};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model_issue(input int d, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          s_a, s_b, q, r;
    longint unsigned u_a, u_b;
    logic [63:0]     p;
    exp_t            x;
    int              e, n;
    e = cyc + 1;
    if (e <= m_done[d]) return;  // unit busy: command ignored
    s_a = $signed(a); s_b = $signed(b);
    u_a = a;          u_b = b;
    x.kind = K_IMM; x.dut = d; x.due = e; x.width = 0;
    n = 0;
    case (op)
      3'd1: begin p = s_a * s_b; m_hi[d] = p[63:32]; m_lo[d] = p[31:0]; n = mc[d]; end
      3'd2: begin p = u_a * u_b; m_hi[d] = p[63:32]; m_lo[d] = p[31:0]; n = mc[d]; end
      3'd3: begin
        if (b != 0) begin q = s_a / s_b; r = s_a % s_b; m_hi[d] = r[W-1:0]; m_lo[d] = q[W-1:0]; end
        n = dc[d];
      end
      3'd4: begin
        if (b != 0) begin m_hi[d] = W'(u_a % u_b); m_lo[d] = W'(u_a / u_b); end
        n = dc[d];
      end
      3'd5: m_hi[d] = a;
      3'd6: m_lo[d] = a;
      default: ;
    endcase
    if (n > 0) begin
      x.kind = K_LONG; x.due = e + n; x.width = n; m_done[d] = e + n;
    end
    x.hi = m_hi[d]; x.lo = m_lo[d];
    sb.push_back(x);
  endtask

  task automatic issue(input int d, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    srcA = a; srcB = b; mduOp = op;
    start = '0; start[d] = 1'b1;
    model_issue(d, op, a, b);
    @(posedge clk); #1;
    // Scramble operands after the start edge: results must not follow them.
    start = '0; mduOp = 3'($urandom); srcA = $urandom; srcB = $urandom;
  endtask

  task automatic wait_idle(input int d);
    while (cyc < m_done[d]) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    exp_t x;
    sb.delete();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_hi[d] = '0; m_lo[d] = '0; m_done[d] = 0;
      x.kind = K_RST; x.dut = d; x.due = cyc + 1; x.width = 0; x.hi = '0; x.lo = '0;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares on busy falling or when an immediate/reset is due.
  initial begin
    int           bw[2];
    logic         pb[2], held[2];
    logic [W-1:0] h0[2], l0[2], ah, al;
    exp_t         x;
    bw = '{0, 0}; pb = '{1'b0, 1'b0}; held = '{1'b1, 1'b1};
    h0 = '{0, 0}; l0 = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ah = (d == 0) ? hi0 : hi1;
        al = (d == 0) ? lo0 : lo1;
        if (sb.size() > 0 && sb[0].dut == d && sb[0].kind != K_LONG && sb[0].due == cyc) begin
          x = sb.pop_front();
          chk(x.kind == K_RST ? "rst_busy" : "imm_busy", d, busy[d], 0);
          chk(x.kind == K_RST ? "rst_hi" : "imm_hi", d, ah, x.hi);
          chk(x.kind == K_RST ? "rst_lo" : "imm_lo", d, al, x.lo);
          bw[d] = 0;
        end else if (busy[d]) begin
          if (!pb[d]) begin h0[d] = ah; l0[d] = al; held[d] = 1'b1; bw[d] = 0; end
          bw[d]++;
          if (ah != h0[d] || al != l0[d]) held[d] = 1'b0;
        end else if (pb[d]) begin
          if (sb.size() == 0 || sb[0].dut != d || sb[0].kind != K_LONG) begin
            checks++; failures++;
            $display("FAIL unexpected_done dut%0d cyc=%0d got=busy_fall exp=none", d, cyc);
          end else begin
            x = sb.pop_front();
            chk("done_cycle", d, cyc, x.due);
            chk("busy_width", d, bw[d], x.width);
            chk("hold_while_busy", d, held[d], 1);
            chk("res_hi", d, ah, x.hi);
            chk("res_lo", d, al, x.lo);
          end
        end
        pb[d] = busy[d];
      end
      if (sb.size() > 0 && cyc > sb[0].due) begin
        x = sb.pop_front();
        checks++; failures++;
        $display("FAIL overdue dut%0d cyc=%0d got=no_response exp=due_%0d", x.dut, cyc, x.due);
      end
    end
  end

  // Stimulus.
  initial begin
    @(posedge clk); #1;
    do_reset();
    // Directed cases on the 5/10 unit.
    issue(0, 3'd1, 32'hFFFF_FFFF, 32'd2);  wait_idle(0);
    issue(0, 3'd2, 32'hFFFF_FFFF, 32'd2);  wait_idle(0);
    issue(0, 3'd3, 32'hFFFF_FFF9, 32'd2);  wait_idle(0);
    issue(0, 3'd4, 32'd7, 32'd2);          wait_idle(0);
    issue(0, 3'd6, 32'h1234, 32'd0);
    issue(0, 3'd5, 32'd1, 32'd0);
    issue(0, 3'd6, 32'd3, 32'd0);
    issue(0, 3'd3, 32'd99, 32'd0);         wait_idle(0);
    issue(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(0);
    // Commands issued while busy must be ignored.
    issue(0, 3'd1, 32'd12345, 32'd678);
    issue(0, 3'd5, 32'hDEAD_BEEF, 32'd0);
    issue(0, 3'd3, 32'd100, 32'd7);        wait_idle(0);
    issue(0, 3'd7, 32'hAAAA_AAAA, 32'd5);
    issue(0, 3'd0, 32'h5555_5555, 32'd5);
    // Reset two cycles into a mult.
    issue(0, 3'd1, 32'd77, 32'd88);
    @(posedge clk); #1;
    do_reset();
    // Randomized traffic, sometimes deliberately colliding with busy.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) wait_idle(0);
      issue(0, 3'($urandom), pick(), ($urandom_range(0, 7) == 0) ? 32'd0 : pick());
    end
    wait_idle(0);
    // Short-latency unit.
    issue(1, 3'd1, 32'hFFFF_FFFF, 32'd2);  wait_idle(1);
    issue(1, 3'd3, 32'hFFFF_FFF9, 32'd2);  wait_idle(1);
    issue(1, 3'd4, 32'd7, 32'd2);          wait_idle(1);
    issue(1, 3'd2, 32'hFFFF_FFFF, 32'd2);  wait_idle(1);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) != 0) wait_idle(1);
      issue(1, 3'($urandom), pick(), pick());
    end
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain cyc=%0d got=%0d_pending exp=0", cyc, sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the pipelined CPU, sitting beside the ALU in the execute stage. It implements the mult/multu/div/divu/mthi/mtlo family against private HI/LO registers. It exposes a registered busy flag so hazard logic can stall HI/LO consumers and new MD instructions. Operand width and per-operation latencies are parameters.

## Interface
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu; must be ≥1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- srcA  in  WIDTH  first operand: multiplicand, dividend, or mthi/mtlo data.
- srcB  in  WIDTH  second operand: multiplier or divisor.
- mduOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- start  in  1  command valid; sampled at the rising edge.
- busy  out  1  registered; 1 while a mult/div is in progress.
- hi  out  WIDTH  HI register, always visible.
- lo  out  WIDTH  LO register, always visible.

## Operation
- Reset: busy=0, hi=0, lo=0, counter=0, pending result cleared.
- Two states: IDLE and BUSY.
- IDLE, start=1, op mult/multu/div/divu:
  - Compute the full result from srcA/srcB at that edge into pending registers (pendHi, pendLo).
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1 and enter BUSY.
- IDLE, start=1, op mthi/mtlo: write srcA to hi/lo at that edge. busy stays 0.
- IDLE, start=1, op none/reserved: no effect.
- BUSY: decrement the counter each edge. On the edge where the counter reaches 0, copy pendHi/pendLo to hi/lo, clear busy, and return to IDLE.
- start while BUSY (any op, including mthi/mtlo): ignored entirely. The stall logic guarantees this does not happen; the unit must still tolerate it.
- Arithmetic:
  - mult: signed 2·WIDTH product; hi = upper half, lo = lower half.
  - multu: unsigned 2·WIDTH product, split the same way.
  - div: signed division truncating toward zero. lo = quotient. hi = remainder, with the sign of the dividend.
  - divu: unsigned division; lo = quotient, hi = remainder.
- Boundary cases:
  - div/divu with srcB=0: operation runs its full DIV_CYCLES with busy, then hi/lo retain their prior values.
  - Signed div of most-negative value by −1: lo = most-negative value (wraps), hi = 0.
  - Operands are captured at the start edge. Later changes to srcA/srcB do not affect the result.
- Reset mid-operation: the in-flight result is discarded. hi=lo=0, busy=0 at the next edge.

## Timing
- Start is sampled at edge E0.
- busy is 1 during the N cycles following E0, where N = MULT_CYCLES or DIV_CYCLES.
- hi/lo update and busy falls together at edge E0+N.
- New values are visible on hi/lo in the cycle after busy falls.
- A new start is accepted in the first cycle busy=0, i.e. sampled at edge E0+N+1 at the earliest (back-to-back allowed).
- mthi/mtlo have 1-edge latency with no busy. hi/lo show the new value in the cycle after the start edge.
- hi/lo/busy are pure registers; there is no combinational path from inputs to outputs.
- Throughput: one mult every MULT_CYCLES+1 cycles; one div every DIV_CYCLES+1 cycles.

## Test plan
- Reset, then mult with srcA=0xFFFFFFFF, srcB=2.
  - busy is high exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - hi/lo hold 0 while busy.
- multu with srcA=0xFFFFFFFF, srcB=2: after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- div with srcA=−7 (0xFFFFFFF9), srcB=2: after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 7/2 back-to-back:
  - Issue divu 7/2 immediately after busy falls: after 10 cycles, lo=3, hi=1.
  - Then mtlo with srcA=0x1234: lo=0x1234 next cycle, busy stays 0.
- Boundary operations:
  - div with srcB=0 after hi=1, lo=3: busy runs 10 cycles, then hi=1, lo=3 unchanged.
  - div 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- Reset mid-operation:
  - Assert reset 2 cycles into a mult: next cycle busy=0, hi=lo=0.
  - mthi issued while busy is ignored.
  - Repeat with MULT_CYCLES=1, DIV_CYCLES=3: busy widths are 1 and 3.
